// File: rtl/sd_uart_rx.sv
// 8N1 UART receiver for the SD card host link: synchronises rx, samples each bit
// at mid-bit and strobes po_flag on a good byte or frame_err on a bad stop bit.
`timescale 1ns/1ps
module sd_uart_rx #(
  parameter int unsigned UART_BPS = 921600,
  parameter int unsigned CLK_FREQ = 20_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int unsigned HALF         = BAUD_CNT_MAX / 2;
  localparam logic [12:0] BAUD_LAST    = 13'(BAUD_CNT_MAX - 1);
  localparam logic [12:0] BAUD_HALF    = 13'(HALF);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic        rx_m;
  logic        rx_s;
  logic        rx_d;
  logic [12:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        fall;
  logic        samp;

  // Synchroniser idles high so reset never looks like a start edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  always_comb begin
    fall = rx_d & ~rx_s;
    samp = (state != IDLE) && (baud_cnt == BAUD_HALF);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      po_data   <= '0;
      po_flag   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      po_flag   <= 1'b0;
      frame_err <= 1'b0;

      if (state == IDLE || baud_cnt == BAUD_LAST) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 13'd1;
      end

      unique case (state)
        IDLE: begin
          if (fall) begin
            state   <= START;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (samp) begin
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (samp) begin
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          // Leave at mid-stop-bit so a start edge right after the stop bit is seen.
          if (samp) begin
            if (rx_s) begin
              po_data <= shift;
              po_flag <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
